// File: rtl/ring_queue_pkg.sv
// Shared constants and helpers for the ring_queue block.
package ring_queue_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_ADDR_WIDTH = 4;

   // Occupancy counter needs one extra bit so that "completely full" (DEPTH) is representable.
   function automatic int count_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage : ring_queue_pkg

// File: rtl/ring_queue_if.sv
// Push/pop handshake bundle between a producer/consumer and the ring_queue.
interface ring_queue_if
   import ring_queue_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   // Producer/consumer side: offers pushes, accepts pops.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   // Queue side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface : ring_queue_if

// File: rtl/ring_queue_mem.sv
// Storage array for ring_queue: one synchronous write port, two combinational read ports.
module ring_queue_mem
   import ring_queue_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
)(
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] head_addr,
   output logic [DATA_WIDTH-1:0] head_data,
   input  logic [ADDR_WIDTH-1:0] peek_addr,
   output logic [DATA_WIDTH-1:0] peek_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Write the pushed entry at the write pointer.
   // NOTE: the array is deliberately not reset; entries are only ever read after being written,
   // and a reset port here would forbid mapping onto RAM/register-file primitives.
   // NOTE: sequential state is always assigned with <= so every reader sees pre-edge values.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign head_data = mem[head_addr];
   assign peek_data = mem[peek_addr];

endmodule : ring_queue_mem

// File: rtl/ring_queue.sv
// Ring-buffer FIFO with occupancy flags, sticky overflow, flush and a registered peek port.
module ring_queue
   import ring_queue_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
   parameter int AFULL_LEVEL = (2**ADDR_WIDTH) - 2
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush,
   ring_queue_if.slave                          q,
   input  logic                                 peek_en,
   input  logic [ADDR_WIDTH-1:0]                peek_off,
   output logic                                 peek_valid,
   output logic [DATA_WIDTH-1:0]                peek_data,
   output logic [count_width(ADDR_WIDTH)-1:0]   count,
   output logic                                 full,
   output logic                                 empty,
   output logic                                 almost_full,
   output logic                                 overflow
);

   localparam int              DEPTH     = 2**ADDR_WIDTH;
   localparam int              CW        = count_width(ADDR_WIDTH);
   localparam logic [CW-1:0]   DEPTH_CNT = CW'(DEPTH);
   localparam logic [CW-1:0]   AFULL_CNT = CW'(AFULL_LEVEL);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] peek_addr;
   logic [DATA_WIDTH-1:0] head_data;
   logic [DATA_WIDTH-1:0] peek_rd_data;
   logic                  push_acc;
   logic                  pop_acc;
   logic                  peek_hit;

   // Flags come straight from count, so an asynchronous reset of count forces them immediately.
   assign full        = (count == DEPTH_CNT);
   assign empty       = (count == '0);
   assign almost_full = (count >= AFULL_CNT);

   assign q.in_ready  = !full;
   assign q.out_valid = !empty;
   // Gate the head so stale or never-written storage is not exposed while empty.
   assign q.out_data  = empty ? '0 : head_data;

   // Flush wins over any traffic in the same cycle.
   assign push_acc  = q.in_valid  && !full  && !flush;
   assign pop_acc   = q.out_valid && q.out_ready && !flush;

   assign peek_addr = rd_ptr + peek_off;
   assign peek_hit  = peek_en && ({1'b0, peek_off} < count);

   ring_queue_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk       (clk),
      .wr_en     (push_acc),
      .wr_addr   (wr_ptr),
      .wr_data   (q.in_data),
      .head_addr (rd_ptr),
      .head_data (head_data),
      .peek_addr (peek_addr),
      .peek_data (peek_rd_data)
   );

   // Pointer, occupancy and sticky overflow bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (pop_acc)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         case ({push_acc, pop_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (q.in_valid && full) overflow <= 1'b1;
      end
   end

   // Registered peek, evaluated against the pointers and count in effect before this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         peek_valid <= 1'b0;
         peek_data  <= '0;
      end else if (flush) begin
         peek_valid <= 1'b0;
         peek_data  <= '0;
      end else begin
         peek_valid <= peek_hit;
         peek_data  <= peek_hit ? peek_rd_data : '0;
      end
   end

endmodule : ring_queue

// File: doc/ring_queue.md
RING_QUEUE -- requirements
Module: ring_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, entry width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, log2 of depth; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous queue clear.
REQ-007 SHALL have ports in_valid input 1, in_ready output 1, in_data input DATA_WIDTH: push handshake.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_data output DATA_WIDTH: pop handshake, head entry.
REQ-009 SHALL have ports peek_en input 1, peek_off input ADDR_WIDTH, peek_valid output 1, peek_data output DATA_WIDTH: offset read from head.
REQ-010 SHALL have ports count output ADDR_WIDTH+1, full output 1, empty output 1, almost_full output 1, overflow output 1.

Function
REQ-011 SHALL accept a push when in_valid && in_ready and pop when out_valid && out_ready, both on the same clk edge.
REQ-012 SHALL drive in_ready = !full; no write-through when full, even with a simultaneous pop.
REQ-013 SHALL drive out_valid = !empty, with out_data = entry at the read pointer, combinational from storage.
REQ-014 SHALL make a pushed entry visible at out_data from the cycle after acceptance if the queue was empty.
REQ-015 SHALL advance write/read pointers by 1 per accepted push/pop, wrapping modulo DEPTH.
REQ-016 SHALL update count +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop; range 0..DEPTH.
REQ-017 SHALL assert full iff count == DEPTH, empty iff count == 0, almost_full iff count >= AFULL_LEVEL.
REQ-018 SHALL set sticky overflow when in_valid && !in_ready; it clears only on rst or flush.
REQ-019 SHALL register peek with one-cycle latency: peek_valid <= peek_en && (peek_off < count); peek_data <= entry at (read pointer + peek_off) mod DEPTH when valid, else 0.
REQ-020 SHALL evaluate peek against pre-edge pointers/count, ignoring same-cycle push/pop.
REQ-021 SHALL give flush priority over push and pop: pointers, count, overflow, and peek_valid go to 0 next edge; storage contents are not cleared.
REQ-022 SHALL ignore pop attempts while empty and push attempts while full, leaving state unchanged apart from overflow.

Reset
REQ-023 SHALL, on rst, immediately clear pointers, count, overflow, peek_valid, and peek_data to 0.
REQ-024 SHALL, during rst, force in_ready=1, empty=1, out_valid=0, full=0, and almost_full=(AFULL_LEVEL==0).
REQ-025 SHALL leave storage contents undefined after reset; no output may depend on them until written.

Structure
REQ-026 SHALL place default width constants and the count-width function (ADDR_WIDTH+1) in shared package ring_queue_pkg.
REQ-027 SHALL instantiate one sub-module, ring_queue_mem, as the storage array: one synchronous write port and two combinational read ports (head, peek).
REQ-028 SHALL keep pointer, count, and flag logic in ring_queue; none of it in ring_queue_mem.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, AFULL_LEVEL=3)
REQ-029 SHALL cover fill and drain: push 0x11,0x22,0x33,0x44 -> full=1, count=4, almost_full from count 3; pop x4 -> out_data 0x11,0x22,0x33,0x44 in order, then empty=1.
REQ-030 SHALL cover wrap-around: six push/pop pairs interleaved with count held at 2 -> FIFO order preserved across the pointer wrap, count stays 2.
REQ-031 SHALL cover push while full: 5th push of 0x55 -> in_ready=0, overflow=1 sticky, count=4, 0x55 never appears at out_data.
REQ-032 SHALL cover peek: queue holds 0xA0,0xB1,0xC2; peek_off=2 -> next cycle peek_valid=1, peek_data=0xC2; peek_off=3 -> peek_valid=0, peek_data=0.
REQ-033 SHALL cover flush with traffic: flush with push and pop both active at count=3 -> next cycle count=0, empty=1, overflow=0.
REQ-034 SHALL cover reset mid-operation: rst asserted asynchronously at count=2 -> outputs at reset values before the next edge, and the first push after release reads back correctly.
